adder_8bit: RTL and testbench

ADDER_8BIT -- requirements
Module: adder_8bit

---
 rtl/adder_8bit.sv | 73 +++++++
 tb/tb_adder_8bit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder with combinational sum/carry/overflow/zero flags
// and a one-cycle registered copy of sum, carry and overflow plus a valid flag.
module adder_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic       zero,
  output logic [7:0] sum_q,
  output logic       cout_q,
  output logic       ovf_q,
  output logic       valid_q
);

  localparam int DATA_W = 8;

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic p;
    p = x ^ y;
    return {(x & y) | (ci & p), p ^ ci};
  endfunction

  logic [DATA_W:0]   carry_p0;
  logic [DATA_W-1:0] sum_p0;

  always_comb begin
    carry_p0    = '0;
    sum_p0      = '0;
    carry_p0[0] = cin;
    for (int i = 0; i < DATA_W; i++) begin
      {carry_p0[i+1], sum_p0[i]} = full_add(a[i], b[i], carry_p0[i]);
    end
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign sum  = sum_p0;
  assign cout = carry_p0[DATA_W];
  assign ovf  = carry_p0[DATA_W-1] ^ carry_p0[DATA_W];
  assign zero = ~|sum_p0;

  // ---- stage p0 -> p1: registered result ----
  logic [DATA_W-1:0] sum_p1;
  logic              cout_p1;
  logic              ovf_p1;
  logic              vld_p1;

  // The registered result must read zero while reset is held, so the data
  // registers share the asynchronous reset with the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sum_p1  <= sum;
      cout_p1 <= cout;
      ovf_p1  <= ovf;
      vld_p1  <= 1'b1;
    end
  end

  assign sum_q   = sum_p1;
  assign cout_q  = cout_p1;
  assign ovf_q   = ovf_p1;
  assign valid_q = vld_p1;

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: arithmetic reference model, directed
// literal vectors, random and exhaustive combinational sweeps, reset behaviour.
`timescale 1ns/1ps
module tb_adder_8bit;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] sum, sum_q;
  logic       cout, ovf, zero, cout_q, ovf_q, valid_q;

  int checks;
  int errors;

  event chk_ev;

  adder_8bit dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q), .valid_q(valid_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
    else        clk = 1'b0;
  end

  // Reference: {zero, ovf, cout, sum[7:0]} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int u, sx, sy, sg;
    logic o;
    u  = int'(x) + int'(y) + int'(ci);
    sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
    sg = sx + sy + int'(ci);
    o  = (sg > 127) || (sg < -128);
    return {((u % 256) == 0), o, (u >= 256), u[7:0]};
  endfunction

  // Expected registered outputs: last sampled model result, cleared by reset.
  logic [7:0] m_sum_q;
  logic       m_cout_q, m_ovf_q, m_valid_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum_q   <= 8'h00;
      m_cout_q  <= 1'b0;
      m_ovf_q   <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      logic [10:0] r;
      r = model(a, b, cin);
      m_sum_q   <= r[7:0];
      m_cout_q  <= r[8];
      m_ovf_q   <= r[9];
      m_valid_q <= 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s a=%h b=%h cin=%b got=%h want=%h t=%0t", name, a, b, cin, got, want, $time);
    end
  endtask

  // Compare process: combinational outputs after every applied vector and
  // registered outputs at every falling edge.
  always @(chk_ev or negedge clk) begin
    logic [10:0] r;
    r = model(a, b, cin);
    cmp("sum",     sum,            r[7:0]);
    cmp("cout",    {7'd0, cout},   {7'd0, r[8]});
    cmp("ovf",     {7'd0, ovf},    {7'd0, r[9]});
    cmp("zero",    {7'd0, zero},   {7'd0, r[10]});
    cmp("sum_q",   sum_q,          m_sum_q);
    cmp("cout_q",  {7'd0, cout_q}, {7'd0, m_cout_q});
    cmp("ovf_q",   {7'd0, ovf_q},  {7'd0, m_ovf_q});
    cmp("valid_q", {7'd0, valid_q}, {7'd0, m_valid_q});
  end

  task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic ci);
    a = x; b = y; cin = ci;
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic lit_comb(input string name, input logic [7:0] s, input logic c,
                          input logic o, input logic z);
    cmp({name, ".sum"},  sum,          s);
    cmp({name, ".cout"}, {7'd0, cout}, {7'd0, c});
    cmp({name, ".ovf"},  {7'd0, ovf},  {7'd0, o});
    cmp({name, ".zero"}, {7'd0, zero}, {7'd0, z});
  endtask

  task automatic lit_reg(input string name, input logic [7:0] s, input logic c,
                         input logic o, input logic v);
    cmp({name, ".sum_q"},   sum_q,            s);
    cmp({name, ".cout_q"},  {7'd0, cout_q},   {7'd0, c});
    cmp({name, ".ovf_q"},   {7'd0, ovf_q},    {7'd0, o});
    cmp({name, ".valid_q"}, {7'd0, valid_q},  {7'd0, v});
  endtask

  typedef struct {
    string      name;
    logic [7:0] x, y;
    logic       ci;
    logic [7:0] s;
    logic       c, o, z;
  } vec_t;

  vec_t vecs[8] = '{
    '{"zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
    '{"cin",     8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0},
    '{"0f+11",   8'h0F, 8'h11, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0},
    '{"55+2a",   8'h55, 8'h2A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0},
    '{"aa+55",   8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0},
    '{"ff+ff",   8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0},
    '{"ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{"7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;
    #3;
    lit_reg("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Combinational vectors while reset is held and no clock runs.
    foreach (vecs[i]) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].ci);
      lit_comb(vecs[i].name, vecs[i].s, vecs[i].c, vecs[i].o, vecs[i].z);
    end
    apply(8'h80, 8'h80, 1'b0);
    lit_comb("80+80", 8'h00, 1'b1, 1'b1, 1'b1);
    lit_reg("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b1;
    #2;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] x, y;
      logic ci;
      x  = 8'($urandom_range(0, 255));
      y  = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      a = x; b = y; cin = ci;
      #1;
      cmp("rand", sum, 8'((int'(x) + int'(y) + int'(ci)) % 256));
      cmp("rand.cout", {7'd0, cout}, {7'd0, (int'(x) + int'(y) + int'(ci)) >= 256});
      #1;
    end
    lit_reg("no_clock", 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 131072; i++) begin
      apply(i[7:0], i[15:8], i[16]);
    end

    // Registered path: reset held while the clock runs.
    rst_n = 1'b0;
    #1;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit_reg("reset_clk", 8'h00, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply(8'hFF, 8'h01, 1'b0);
    lit_reg("pre_edge", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    lit_reg("first_edge", 8'h00, 1'b1, 1'b0, 1'b1);

    // Inputs changing twice between edges: only the last value is captured.
    @(posedge clk);
    #2;
    apply(8'h7F, 8'h01, 1'b0);
    apply(8'h10, 8'h20, 1'b1);
    @(posedge clk);
    #1;
    lit_reg("last_value", 8'h31, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      apply(8'(8'h23 * i + 8'h5A), 8'(8'hC7 - 8'h31 * i), 1'(i));
    end
    @(posedge clk);
    #2;
    apply(8'h80, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    lit_reg("neg_ovf", 8'h7F, 1'b1, 1'b1, 1'b1);

    // Reset mid-operation clears immediately; capture resumes after release.
    #1;
    apply(8'h3C, 8'hC4, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    lit_reg("async_clear", 8'h00, 1'b0, 1'b0, 1'b0);
    lit_comb("reset_comb", 8'h01, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    lit_reg("reset_edge", 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    lit_reg("released", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    lit_reg("recapture", 8'h01, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
